// File: rtl/acc_dump_reader.sv
// Debug read-out engine: halts the datapath, walks every accumulator through one
// read port and streams (address, data) beats on a valid/ready interface.
module acc_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] readAddr,
  input  logic [DATA_W-1:0] readData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [DATA_W-1:0] outData,
  output logic              haltReq,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
  logic                out_valid_q, out_valid_d;
  logic                halt_req_q, halt_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and datapath decisions; abort outranks a completing handshake.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          idx_d   = {ADDR_W{1'b0}};
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          out_data_d = readData;
          out_addr_d = idx_q;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (outReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags are decoded from the next state so they leave the block as flops.
  always_comb begin
    out_valid_d = 1'b0;
    halt_req_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    read_addr_d = {ADDR_W{1'b0}};
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_FETCH: begin
        halt_req_d  = 1'b1;
        busy_d      = 1'b1;
        read_addr_d = idx_d;
      end
      S_SEND: begin
        out_valid_d = 1'b1;
        halt_req_d  = 1'b1;
        busy_d      = 1'b1;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      idx_q       <= {ADDR_W{1'b0}};
      out_addr_q  <= {ADDR_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      read_addr_q <= {ADDR_W{1'b0}};
      out_valid_q <= 1'b0;
      halt_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      read_addr_q <= read_addr_d;
      out_valid_q <= out_valid_d;
      halt_req_q  <= halt_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign readAddr = read_addr_q;
  assign outValid = out_valid_q;
  assign outAddr  = out_addr_q;
  assign outData  = out_data_q;
  assign haltReq  = halt_req_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
